// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core: data width, opcode field position,
// HLT encoding and the fetch FSM state encoding.
package core_pkg;

  localparam int CORE_W  = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  localparam logic [3:0] HLT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    FS_REQ   = 2'd0,
    FS_WAIT  = 2'd1,
    FS_VALID = 2'd2,
    FS_HALT  = 2'd3
  } fetch_state_e;

  function automatic logic is_hlt(input logic [CORE_W-1:0] word);
    return word[OPC_MSB:OPC_LSB] == HLT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Saturating up-counter with synchronous clear and count enable; tc is high
// while the count sits at LIMIT.
module fetch_timer #(
  parameter int W     = 8,
  parameter int LIMIT = 14
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != LIMIT_V)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == LIMIT_V);

endmodule

// File: rtl/fetch_unit.sv
// PC owner and instruction fetch sequencer (REQ -> WAIT -> VALID, HLT freezes).
// Optional fetch timeout/retry is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [CORE_W-1:0] RESET_PC = 16'h0000,
  parameter int                MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [CORE_W-1:0] pc_cur,
  input  logic [CORE_W-1:0] next_pc,
  input  logic              stall,
  output logic              imem_req,
  output logic [CORE_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [CORE_W-1:0] imem_rdata,
  output logic [CORE_W-1:0] instr,
  output logic              instr_valid,
  output logic              halted,
  output logic              fetch_err
);

  fetch_state_e      state_reg, state_next;
  logic [CORE_W-1:0] pc_reg, pc_next;
  logic [CORE_W-1:0] instr_reg, instr_next;
  logic              instr_valid_reg, instr_valid_next;
  logic              halted_reg, halted_next;
  logic              halt_pend_reg, halt_pend_next;
  logic              imem_req_reg, imem_req_next;
  logic              timeout;
  logic              unused_ok;

  // Instructions are halfword aligned, so next_pc[0] is never stored.
  assign unused_ok = next_pc[0] & (MAX_WAIT > 0);

`ifdef FETCH_TIMEOUT_EN
  logic timer_clr;
  logic timer_en;
  logic fetch_err_reg;

  assign timer_clr = (state_reg == FS_REQ);
  assign timer_en  = (state_reg == FS_WAIT) && !imem_ack;

  // tc rises during the MAX_WAIT-th ack-less WAIT cycle.
  fetch_timer #(
    .W     (8),
    .LIMIT (MAX_WAIT - 1)
  ) u_fetch_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .tc    (timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_err_reg <= 1'b0;
    end else begin
      fetch_err_reg <= (state_reg == FS_WAIT) && !imem_ack && timeout;
    end
  end

  assign fetch_err = fetch_err_reg;
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    instr_next       = instr_reg;
    instr_valid_next = instr_valid_reg;
    halted_next      = halted_reg;
    halt_pend_next   = halt_pend_reg;
    imem_req_next    = 1'b0;

    case (state_reg)
      // Reset leaves imem_req low, so the first REQ after reset spends one
      // extra cycle raising it; every later REQ is entered with it already set.
      FS_REQ: begin
        if (imem_req_reg) begin
          state_next = FS_WAIT;
        end else begin
          imem_req_next = 1'b1;
        end
      end

      FS_WAIT: begin
        if (imem_ack) begin
          instr_next       = imem_rdata;
          instr_valid_next = 1'b1;
          halt_pend_next   = is_hlt(imem_rdata);
          state_next       = FS_VALID;
        end else if (timeout) begin
          state_next    = FS_REQ;
          imem_req_next = 1'b1;
        end
      end

      FS_VALID: begin
        if (!stall) begin
          instr_valid_next = 1'b0;
          if (halt_pend_reg) begin
            halted_next = 1'b1;
            state_next  = FS_HALT;
          end else begin
            pc_next       = {next_pc[CORE_W-1:1], 1'b0};
            state_next    = FS_REQ;
            imem_req_next = 1'b1;
          end
        end
      end

      FS_HALT: begin
        state_next = FS_HALT;
      end

      default: begin
        state_next = FS_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= FS_REQ;
      pc_reg          <= RESET_PC;
      instr_reg       <= '0;
      instr_valid_reg <= 1'b0;
      halted_reg      <= 1'b0;
      halt_pend_reg   <= 1'b0;
      imem_req_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      instr_reg       <= instr_next;
      instr_valid_reg <= instr_valid_next;
      halted_reg      <= halted_next;
      halt_pend_reg   <= halt_pend_next;
      imem_req_reg    <= imem_req_next;
    end
  end

  assign pc_cur      = pc_reg;
  assign imem_addr   = pc_reg;
  assign imem_req    = imem_req_reg;
  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign halted      = halted_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model checked every cycle,
// plus literal expectations for the main scenarios.
module tb_fetch_unit;

  localparam logic [15:0] RST_PC = 16'h0040;
  localparam int          MW     = 15;
`ifdef FETCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] pc_cur;
  logic [15:0] next_pc;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        halted;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .MAX_WAIT (MW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_cur      (pc_cur),
    .next_pc     (next_pc),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .halted      (halted),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder plus a manual ack path for hand-placed acks.
  logic        resp_ack = 1'b0;
  logic [15:0] resp_data = 16'h0000;
  logic        man_ack = 1'b0;
  logic [15:0] man_data = 16'h0000;
  bit          resp_en = 1'b1;
  int          ack_delay = 0;
  int          resp_cnt = -1;
  logic [15:0] mem [logic [15:0]];

  assign imem_ack   = resp_ack | man_ack;
  assign imem_rdata = resp_ack ? resp_data : man_data;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'h1000 | (a & 16'h0FFF);
  endfunction

  always @(negedge clk) begin
    resp_ack = 1'b0;
    if (!rst_n) begin
      resp_cnt = -1;
    end else if (resp_cnt == 0) begin
      resp_ack  = 1'b1;
      resp_data = mem_word(imem_addr);
      resp_cnt  = -1;
    end else if (resp_cnt > 0) begin
      resp_cnt = resp_cnt - 1;
    end
    if (resp_en && rst_n && imem_req === 1'b1 && ack_delay >= 0) resp_cnt = ack_delay;
  end

  // Transaction-level model: one fetch outstanding at a time, ack counted
  // only once the request has been presented, retire when stall is low.
  bit          m_live = 1'b0;
  bit          m_req, m_busy, m_valid, m_hlt, m_halted, m_err;
  int          m_waited;
  logic [15:0] m_pc, m_instr;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_live   <= 1'b1;
      m_pc     <= RST_PC;
      m_req    <= 1'b0;
      m_busy   <= 1'b0;
      m_valid  <= 1'b0;
      m_hlt    <= 1'b0;
      m_halted <= 1'b0;
      m_err    <= 1'b0;
      m_waited <= 0;
    end else if (m_live) begin
      m_req <= 1'b0;
      m_err <= 1'b0;
      if (m_req) begin
        m_busy   <= 1'b1;
        m_waited <= 0;
      end else if (m_busy) begin
        if (imem_ack) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b1;
          m_instr <= imem_rdata;
          m_hlt   <= (imem_rdata >= 16'hF000);
        end else if (TO_EN && (m_waited + 1 == MW)) begin
          m_busy <= 1'b0;
          m_err  <= 1'b1;
          m_req  <= 1'b1;
        end else begin
          m_waited <= m_waited + 1;
        end
      end else if (m_valid) begin
        if (!stall) begin
          m_valid <= 1'b0;
          if (m_hlt) begin
            m_halted <= 1'b1;
          end else begin
            m_pc  <= next_pc & 16'hFFFE;
            m_req <= 1'b1;
          end
        end
      end else if (!m_halted) begin
        m_req <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_pc_cur", pc_cur, m_pc);
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_imem_req", {15'd0, imem_req}, {15'd0, m_req});
      chk("m_instr_valid", {15'd0, instr_valid}, {15'd0, m_valid});
      chk("m_halted", {15'd0, halted}, {15'd0, m_halted});
      chk("m_fetch_err", {15'd0, fetch_err}, {15'd0, m_err});
      if (m_valid) chk("m_instr", instr, m_instr);
    end
  end

  task automatic wait_req(input logic [15:0] exp_addr, input string nm);
    int n = 0;
    while (imem_req !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL %s: no imem_req within 60 cycles", nm);
    end else begin
      chk(nm, imem_addr, exp_addr);
    end
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (instr_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL %s: instr_valid low for 60 cycles", nm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, e, r;
    rst_n   = 1'b0;
    stall   = 1'b0;
    next_pc = 16'h0042;
    mem[16'h0040] = 16'h1234;
    mem[16'h0042] = 16'h2222;
    mem[16'h0002] = 16'hF000;

    // Reset state and the first fetch from RESET_PC.
    repeat (2) @(negedge clk);
    chk("rst_pc", pc_cur, 16'h0040);
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    rst_n = 1'b1;
    wait_req(16'h0040, "first_req_addr");
    wait_valid("first_valid");
    chk("first_instr", instr, 16'h1234);
    @(negedge clk);
    chk("first_valid_one_cycle", {15'd0, instr_valid}, 16'd0);
    chk("pc_after_retire", pc_cur, 16'h0042);
    wait_req(16'h0042, "second_req_addr");
    $display("txn fetch 0040 -> instr 1234, pc 0042");

    // Stall held across four VALID cycles.
    stall   = 1'b1;
    next_pc = 16'h0100;
    wait_valid("stall_valid");
    for (int i = 0; i < 4; i++) begin
      chk("stall_instr", instr, 16'h2222);
      chk("stall_valid_hold", {15'd0, instr_valid}, 16'd1);
      chk("stall_pc_hold", pc_cur, 16'h0042);
      chk("stall_no_req", {15'd0, imem_req}, 16'd0);
      @(negedge clk);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("unstall_retire_pc", pc_cur, 16'h0100);
    chk("unstall_valid", {15'd0, instr_valid}, 16'd0);
    wait_req(16'h0100, "unstall_req_addr");
    $display("txn stall x4 on 0042, retire -> pc 0100");

    // Odd next_pc is aligned; wrap through FFFE to 0000.
    next_pc = 16'h0077;
    wait_valid("odd_valid");
    @(negedge clk);
    chk("odd_next_pc", pc_cur, 16'h0076);
    wait_req(16'h0076, "odd_req_addr");
    next_pc = 16'hFFFE;
    wait_valid("fffe_valid");
    @(negedge clk);
    wait_req(16'hFFFE, "fffe_req_addr");
    next_pc = 16'h0000;
    wait_valid("wrap_valid");
    @(negedge clk);
    wait_req(16'h0000, "wrap_req_addr");
    $display("txn next_pc 0077 -> 0076, then FFFE, then 0000");

    // HLT at 0002 freezes the core.
    next_pc = 16'h0002;
    wait_valid("pre_hlt_valid");
    @(negedge clk);
    wait_req(16'h0002, "hlt_req_addr");
    next_pc = 16'h1234;
    wait_valid("hlt_valid");
    chk("hlt_instr", instr, 16'hF000);
    @(negedge clk);
    chk("hlt_halted", {15'd0, halted}, 16'd1);
    chk("hlt_pc_frozen", pc_cur, 16'h0002);
    chk("hlt_valid_clear", {15'd0, instr_valid}, 16'd0);
    r = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req === 1'b1) r++;
    end
    chk("hlt_no_req", r[15:0], 16'd0);
    chk("hlt_pc_still", pc_cur, 16'h0002);
    rst_n   = 1'b0;
    resp_en = 1'b0;
    @(negedge clk);
    chk("hlt_reset_pc", pc_cur, 16'h0040);
    chk("hlt_reset_halted", {15'd0, halted}, 16'd0);
    $display("txn HLT at 0002, 20 idle cycles, reset -> pc 0040");

    // Reset during WAIT, then a stale ack after release.
    rst_n = 1'b1;
    wait_req(16'h0040, "pre_abort_req");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("fresh_req", {15'd0, imem_req}, 16'd1);
    chk("fresh_req_addr", imem_addr, 16'h0040);
    man_ack  = 1'b1;
    man_data = 16'hBEEF;
    @(negedge clk);
    man_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stale_ack_ignored", {15'd0, instr_valid}, 16'd0);
      @(negedge clk);
    end
    next_pc  = 16'h0200;
    man_ack  = 1'b1;
    man_data = 16'h5555;
    @(negedge clk);
    man_ack = 1'b0;
    chk("new_ack_valid", {15'd0, instr_valid}, 16'd1);
    chk("new_ack_instr", instr, 16'h5555);
    wait_req(16'h0200, "after_abort_req");
    $display("txn reset in WAIT, stale ack ignored, fresh fetch 5555");

`ifdef FETCH_TIMEOUT_EN
    // No ack: timeout after MAX_WAIT WAIT cycles, retry at the same pc.
    @(negedge clk);
    n = 1;
    resp_en   = 1'b1;
    ack_delay = MW - 1;
    while (fetch_err !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n[15:0], 16'd16);
    chk("retry_req", {15'd0, imem_req}, 16'd1);
    chk("retry_addr", imem_addr, 16'h0200);
    // Ack on the terminal WAIT cycle wins over the timeout.
    n = 0;
    e = 0;
    while (instr_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (fetch_err === 1'b1) e++;
    end
    chk("terminal_ack_cycles", n[15:0], 16'd16);
    chk("terminal_ack_no_err", e[15:0], 16'd0);
    $display("txn timeout at 0200 after 15 WAIT cycles, retry acked on terminal cycle");
`else
    e = 0;
    r = 0;
    repeat (40) begin
      @(negedge clk);
      if (fetch_err === 1'b1) e++;
      if (imem_req === 1'b1) r++;
    end
    chk("no_timeout_err", e[15:0], 16'd0);
    chk("no_retry_req", r[15:0], 16'd0);
    chk("still_waiting", {15'd0, instr_valid}, 16'd0);
    $display("txn unacked fetch at 0200 waits 40 cycles without error");
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Owns the architectural PC register for the 16-bit single-cycle core and sequences instruction fetches from instruction memory.
- Uses a req/ack handshake, so memory latency can span several cycles.
- Presents the current PC to the downstream branch/next-PC logic.
- Latches that logic's next_pc when the decoded instruction retires.
- Detects HLT (opcode 4'hF) and freezes the PC.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- MAX_WAIT, 15, cycles in WAIT without ack before a fetch timeout (valid range 1..255).

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- pc_cur  out  16  current PC; feeds next-PC logic and imem_addr.
- next_pc  in  16  next PC from the branch/next-PC stage; bit 0 ignored (forced 0 on load).
- stall  in  1  hazard hold; blocks retire while high.
- imem_req  out  1  single-cycle fetch request pulse.
- imem_addr  out  16  fetch address, equal to pc_cur.
- imem_ack  in  1  memory data valid.
- imem_rdata  in  16  fetched instruction word.
- instr  out  16  held instruction for decode.
- instr_valid  out  1  instr is valid and awaiting retire.
- halted  out  1  HLT retired; core frozen.
- fetch_err  out  1  one-cycle pulse on fetch timeout.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values (rst_n=0 at posedge):
  - pc=RESET_PC, state=REQ, imem_req=0, instr=16'h0000, instr_valid=0, halted=0, fetch_err=0, halt_pend=0, timer=0.
  - Reset mid-WAIT abandons the outstanding fetch. A late ack after reset is ignored unless state is WAIT.
- States: REQ, WAIT, VALID, HALT. All outputs are registered.
- REQ:
  - imem_req=1 for exactly this cycle, imem_addr=pc.
  - Next state WAIT, timer cleared.
- WAIT:
  - imem_req=0. imem_ack is sampled only in this state; ack in REQ is ignored.
  - On ack: instr<=imem_rdata, instr_valid<=1, halt_pend<=(imem_rdata[15:12]==4'hF), go VALID.
  - Without ack: timer increments.
- VALID:
  - instr_valid=1, instr stable.
  - If stall=1: hold everything, including pc.
  - If stall=0 (retire):
    - With halt_pend=0: pc<={next_pc[15:1],1'b0}, instr_valid<=0, go REQ.
    - With halt_pend=1: pc unchanged, instr_valid<=0, halted<=1, go HALT.
- HALT:
  - Terminal state. No requests; pc frozen; halted=1. Exit only via reset.
- Latency: minimum fetch-to-retire is 3 cycles (REQ, WAIT with same-cycle ack, VALID with no stall), i.e. one instruction per 3 cycles.
- Wrap-around: next_pc=16'hFFFE followed by +2 naturally produces 16'h0000; no special handling.
- Simultaneous events:
  - stall has no effect outside VALID.
  - ack arriving on the same cycle the timeout would fire: ack wins, no fetch_err.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - In WAIT, when timer reaches MAX_WAIT without ack, fetch_err pulses for one cycle and state returns to REQ (retry at the same pc).
  - An ack arriving in that REQ cycle is ignored.
- Undefined:
  - WAIT persists indefinitely; fetch_err is tied 0; the timer is not instantiated.

Decomposition:
- Shared package core_pkg:
  - Fetch state encoding (REQ=2'd0, WAIT=2'd1, VALID=2'd2, HALT=2'd3).
  - HLT_OPCODE=4'hF.
  - Opcode field position [15:12].
  - Core width constant 16.
- One sub-module, fetch_timer:
  - Saturating counter with clear/enable inputs and a terminal-count output.
  - Instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset with RESET_PC=16'h0040, ack 1 cycle after req, rdata=16'h1234, stall=0, next_pc=16'h0042:
  - imem_req pulses with addr 0040.
  - instr=1234 with instr_valid for 1 cycle.
  - pc=0042 and the next req goes to 0042.
- Hold stall=1 for 4 cycles in VALID:
  - instr, instr_valid and pc remain stable.
  - No imem_req.
  - Retire occurs on the first cycle stall=0.
- Fetch returns rdata=16'hF000:
  - After retire, halted=1 and pc holds its value.
  - No further imem_req for 20 cycles; rst_n low restores pc=RESET_PC.
- next_pc=16'h0077 at retire:
  - pc becomes 16'h0076.
  - With next_pc=16'hFFFE then 16'h0000, both addresses are fetched.
- With FETCH_TIMEOUT_EN and MAX_WAIT=15, no ack:
  - fetch_err pulses after 15 WAIT cycles and a new req goes to the same pc.
  - A case with ack on the terminal cycle gives no fetch_err.
- Assert rst_n low during WAIT, then deliver ack 1 cycle after reset release:
  - The stale ack is ignored.
  - Fresh req to RESET_PC; instr_valid stays 0 until the new ack.
